dmem_arbiter: RTL and testbench

- Shares the single-ported byte-addressed DataMemory (128 bytes, big-endian 16-bit words) between two requesters: port 0 = CPU load/store stage, port 1 = debug/DMA loader.
- Uses a request/acknowledge handshake, round-robin or fixed-priority arbitration and a 3-state access sequencer.
- Drives the memory's address, write-data, write-enable and read-enable lines, and returns captured read data.
- Sits between the CPU MEM stage and DataMemory.

---
 rtl/dmem_arb_pkg.sv | 33 +++
 rtl/rr_arbiter_2.sv | 50 +++++
 rtl/dmem_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the DataMemory arbiter:
//   - access sequencer state encoding (IDLE / ACCESS / RESP)
//   - requester port indices (P_CPU = CPU MEM stage, P_DBG = debug/DMA loader)
//   - default memory depth in bytes
//   - small helper turning a port index into a one-hot grant vector
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

  localparam int DEF_MEM_BYTES = 128;

  // One-hot grant vector for a given port index.
  function automatic logic [1:0] onehot_of(input logic idx);
    logic [1:0] oh;
    if (idx == P_DBG) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Two-requester arbiter, round-robin or fixed priority.
// The pointer holds the index of the port granted last; on a tie the other
// port wins unless fixed_prio forces port 0.
//
// Ports:
//   req0, req1  in   request lines of port 0 / port 1
//   ptr         in   index of the port granted last
//   fixed_prio  in   1 = port 0 always wins a tie
//   gnt         out  one-hot grant (bit 0 = port 0, bit 1 = port 1)
//   ptr_nxt     out  pointer value to store if this grant is taken
// ---------------------------------------------------------------------------
module rr_arbiter_2
  import dmem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  input  logic       fixed_prio,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  // Grant selection and pointer update.
  always_comb begin
    gnt     = 2'b00;
    ptr_nxt = ptr;
    if (req0 && req1) begin
      // Tie: port 0 wins when priority is fixed or when port 1 went last.
      if (fixed_prio || (ptr == P_DBG)) begin
        gnt     = onehot_of(P_CPU);
        ptr_nxt = P_CPU;
      end else begin
        gnt     = onehot_of(P_DBG);
        ptr_nxt = P_DBG;
      end
    end else if (req0) begin
      gnt     = onehot_of(P_CPU);
      ptr_nxt = P_CPU;
    end else if (req1) begin
      gnt     = onehot_of(P_DBG);
      ptr_nxt = P_DBG;
    end else begin
      gnt     = 2'b00;
      ptr_nxt = ptr;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported, byte-addressed DataMemory between the CPU MEM
// stage (port 0) and the debug/DMA loader (port 1). Each access takes three
// cycles: IDLE samples and latches the winner, ACCESS drives the memory,
// RESP pulses the winner's Ack. Out-of-range accesses are flagged with Err
// and never reach the memory.
//
// Ports:
//   Clock, Reset_n          clock, asynchronous active-low reset
//   Req0/1, Wr0/1           request (held until Ack), 1 = store / 0 = load
//   Addr0/1, WData0/1       byte address of the word, store data
//   Ack0/1, Err0/1          one-cycle completion pulse, range error with Ack
//   RData                   captured load data (0 after an error access)
//   Busy                    high whenever the sequencer is not in IDLE
//   MemAdresa, MemWData     address / write data to DataMemory
//   MemWrite, MemRead       write / read enables to DataMemory
//   MemRData                combinational read data from DataMemory
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_BYTES  = DEF_MEM_BYTES,
  parameter int FIXED_PRIO = 0
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Ack0,
  output logic              Ack1,
  output logic              Err0,
  output logic              Err1,
  output logic [DATA_W-1:0] RData,
  output logic              Busy,
  output logic [ADDR_W-1:0] MemAdresa,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemRData
);

  // A word touches Addr and Addr+1, so the last legal start address is
  // MEM_BYTES-2. Nothing wraps; larger addresses are flagged.
  localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 2);

  arb_state_t        state_r;
  arb_state_t        state_nxt_s;

  logic              rr_ptr_r;
  logic              ptr_nxt_s;
  logic [1:0]        gnt_s;
  logic              any_gnt_s;

  logic              win_r;
  logic              wr_r;
  logic              err_r;

  logic              sel_idx_s;
  logic              sel_wr_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_err_s;

  logic              ack0_nxt_s;
  logic              ack1_nxt_s;
  logic              err0_nxt_s;
  logic              err1_nxt_s;
  logic [DATA_W-1:0] rdata_nxt_s;
  logic              busy_nxt_s;
  logic [ADDR_W-1:0] adr_nxt_s;
  logic [DATA_W-1:0] wd_nxt_s;
  logic              mwr_nxt_s;
  logic              mrd_nxt_s;

  rr_arbiter_2 u_arb (
    .req0       (Req0),
    .req1       (Req1),
    .ptr        (rr_ptr_r),
    .fixed_prio (FIXED_PRIO != 0),
    .gnt        (gnt_s),
    .ptr_nxt    (ptr_nxt_s)
  );

  assign any_gnt_s = |gnt_s;

  // Route the winning requester's command fields.
  always_comb begin
    if (gnt_s[1]) begin
      sel_idx_s   = P_DBG;
      sel_wr_s    = Wr1;
      sel_addr_s  = Addr1;
      sel_wdata_s = WData1;
    end else begin
      sel_idx_s   = P_CPU;
      sel_wr_s    = Wr0;
      sel_addr_s  = Addr0;
      sel_wdata_s = WData0;
    end
  end

  assign sel_err_s = (sel_addr_s > LAST_OK);

  // Sequencer state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sequencer next-state logic: IDLE waits for a request, then one cycle
  // each of ACCESS and RESP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_gnt_s) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS:  state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Transaction latches and round-robin pointer; only IDLE takes a grant,
  // so request changes in ACCESS/RESP have no effect.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr_r <= P_DBG;
      win_r    <= P_CPU;
      wr_r     <= 1'b0;
      err_r    <= 1'b0;
    end else if ((state_r == IDLE) && any_gnt_s) begin
      rr_ptr_r <= ptr_nxt_s;
      win_r    <= sel_idx_s;
      wr_r     <= sel_wr_s;
      err_r    <= sel_err_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
      win_r    <= win_r;
      wr_r     <= wr_r;
      err_r    <= err_r;
    end
  end

  // Next values of the registered outputs. Memory enables are set up on the
  // grant edge so they are high exactly during ACCESS; Ack/Err are set up on
  // the ACCESS edge so they are high exactly during RESP.
  always_comb begin
    ack0_nxt_s  = 1'b0;
    ack1_nxt_s  = 1'b0;
    err0_nxt_s  = 1'b0;
    err1_nxt_s  = 1'b0;
    rdata_nxt_s = RData;
    busy_nxt_s  = (state_nxt_s != IDLE);
    adr_nxt_s   = MemAdresa;
    wd_nxt_s    = MemWData;
    mwr_nxt_s   = 1'b0;
    mrd_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_gnt_s) begin
          adr_nxt_s = sel_addr_s;
          wd_nxt_s  = sel_wdata_s;
          mwr_nxt_s = sel_wr_s & ~sel_err_s;
          mrd_nxt_s = ~sel_wr_s & ~sel_err_s;
        end else begin
          adr_nxt_s = MemAdresa;
          wd_nxt_s  = MemWData;
        end
      end
      ACCESS: begin
        // Error accesses return zero; stores leave the last load data.
        if (err_r) begin
          rdata_nxt_s = {DATA_W{1'b0}};
        end else if (!wr_r) begin
          rdata_nxt_s = MemRData;
        end else begin
          rdata_nxt_s = RData;
        end
        if (win_r == P_DBG) begin
          ack1_nxt_s = 1'b1;
          err1_nxt_s = err_r;
        end else begin
          ack0_nxt_s = 1'b1;
          err0_nxt_s = err_r;
        end
      end
      RESP: begin
        rdata_nxt_s = RData;
      end
      default: begin
        rdata_nxt_s = RData;
      end
    endcase
  end

  // Output registers; reset drops MemWrite at once, abandoning any access.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Ack0      <= 1'b0;
      Ack1      <= 1'b0;
      Err0      <= 1'b0;
      Err1      <= 1'b0;
      RData     <= {DATA_W{1'b0}};
      Busy      <= 1'b0;
      MemAdresa <= {ADDR_W{1'b0}};
      MemWData  <= {DATA_W{1'b0}};
      MemWrite  <= 1'b0;
      MemRead   <= 1'b0;
    end else begin
      Ack0      <= ack0_nxt_s;
      Ack1      <= ack1_nxt_s;
      Err0      <= err0_nxt_s;
      Err1      <= err1_nxt_s;
      RData     <= rdata_nxt_s;
      Busy      <= busy_nxt_s;
      MemAdresa <= adr_nxt_s;
      MemWData  <= wd_nxt_s;
      MemWrite  <= mwr_nxt_s;
      MemRead   <= mrd_nxt_s;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Two arbiters (index 0 round-robin, index 1 fixed priority) driven by the
// same requesters, each with its own 128-byte DataMemory. A transaction-level
// model predicts every output on each falling edge; directed sequences add
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MB = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = 16'h0000, addr1 = 16'h0000;
  logic [DW-1:0] wdata0 = 16'h0000, wdata1 = 16'h0000;

  logic [1:0]    ack0, ack1, err0, err1, busy, mwr, mrd;
  logic [AW-1:0] madr [2];
  logic [DW-1:0] mwd [2], rdata [2], mrdata [2];
  logic [7:0]    dm [2][MB];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 3 + 1);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(MB), .FIXED_PRIO(k)) dut (
      .Clock(clk), .Reset_n(rst_n),
      .Req0(req0), .Req1(req1), .Wr0(wr0), .Wr1(wr1),
      .Addr0(addr0), .Addr1(addr1), .WData0(wdata0), .WData1(wdata1),
      .Ack0(ack0[k]), .Ack1(ack1[k]), .Err0(err0[k]), .Err1(err1[k]),
      .RData(rdata[k]), .Busy(busy[k]),
      .MemAdresa(madr[k]), .MemWData(mwd[k]), .MemWrite(mwr[k]), .MemRead(mrd[k]),
      .MemRData(mrdata[k])
    );
  end

  // DataMemory models: big-endian word, combinational read, write on posedge.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      if (madr[k] <= 16'd126) mrdata[k] = {dm[k][madr[k][6:0]], dm[k][madr[k][6:0] + 7'd1]};
      else mrdata[k] = 16'h0000;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < MB; i++) dm[k][i] <= pat(i);
      end else if (mwr[k]) begin
        dm[k][madr[k][6:0]]        <= mwd[k][15:8];
        dm[k][madr[k][6:0] + 7'd1] <= mwd[k][7:0];
      end
    end
  end

  // ---------------- transaction-level model ----------------
  int            cyc;
  bit            m_act [2];
  int            m_gcyc [2], m_win [2], m_last [2];
  logic          m_wr [2], m_err [2];
  logic [15:0]   m_addr [2], m_wd [2], m_rdata [2];
  logic [7:0]    gm [2][MB];

  function automatic int pick(input int k, input logic r0, input logic r1, input int last);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (k == 1) return 0;
    return (last == 0) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int k = 0; k < 2; k++) begin
        m_act[k] <= 1'b0; m_gcyc[k] <= 0; m_last[k] <= 1; m_rdata[k] <= 16'h0000;
        for (int i = 0; i < MB; i++) gm[k][i] <= pat(i);
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
        // Edge that ends the access cycle: memory commit / data capture.
        if (m_act[k] && (cyc - m_gcyc[k] == 0)) begin
          if (m_err[k]) m_rdata[k] <= 16'h0000;
          else if (m_wr[k]) begin
            gm[k][m_addr[k][6:0]]        <= m_wd[k][15:8];
            gm[k][m_addr[k][6:0] + 7'd1] <= m_wd[k][7:0];
          end else m_rdata[k] <= {gm[k][m_addr[k][6:0]], gm[k][m_addr[k][6:0] + 7'd1]};
        end
        // Free again two edges after a grant; a new grant needs a request.
        if ((!m_act[k] || (cyc - m_gcyc[k] >= 2)) && (req0 || req1)) begin
          m_act[k]  <= 1'b1;
          m_gcyc[k] <= cyc + 1;
          m_win[k]  <= pick(k, req0, req1, m_last[k]);
          m_last[k] <= pick(k, req0, req1, m_last[k]);
          m_wr[k]   <= (pick(k, req0, req1, m_last[k]) == 1) ? wr1 : wr0;
          m_addr[k] <= (pick(k, req0, req1, m_last[k]) == 1) ? addr1 : addr0;
          m_wd[k]   <= (pick(k, req0, req1, m_last[k]) == 1) ? wdata1 : wdata0;
          m_err[k]  <= (((pick(k, req0, req1, m_last[k]) == 1) ? addr1 : addr0) > 16'(MB - 2));
        end
      end
    end
  end

  // ---------------- comparison helpers ----------------
  task automatic chk1(input string n, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", n, got, exp, $time);
    end
  endtask

  task automatic chk16(input string n, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic chki(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  // Per-cycle compare of both DUTs against the model.
  int   cd;
  logic c_acc, c_rsp;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cd    = cyc - m_gcyc[k];
      c_acc = m_act[k] && rst_n && (cd == 0);
      c_rsp = m_act[k] && rst_n && (cd == 1);
      chk1($sformatf("busy[%0d]", k), busy[k], c_acc | c_rsp);
      chk1($sformatf("memwrite[%0d]", k), mwr[k], c_acc & m_wr[k] & ~m_err[k]);
      chk1($sformatf("memread[%0d]", k), mrd[k], c_acc & ~m_wr[k] & ~m_err[k]);
      chk1($sformatf("ack0[%0d]", k), ack0[k], c_rsp && (m_win[k] == 0));
      chk1($sformatf("ack1[%0d]", k), ack1[k], c_rsp && (m_win[k] == 1));
      chk1($sformatf("err0[%0d]", k), err0[k], c_rsp && (m_win[k] == 0) && m_err[k]);
      chk1($sformatf("err1[%0d]", k), err1[k], c_rsp && (m_win[k] == 1) && m_err[k]);
      chk16($sformatf("rdata[%0d]", k), rdata[k], m_rdata[k]);
      if (c_acc) chk16($sformatf("memadresa[%0d]", k), madr[k], m_addr[k]);
      if (c_acc && m_wr[k]) chk16($sformatf("memwdata[%0d]", k), mwd[k], m_wd[k]);
      if (!rst_n) begin
        chk16($sformatf("rst memadresa[%0d]", k), madr[k], 16'h0000);
        chk16($sformatf("rst memwdata[%0d]", k), mwd[k], 16'h0000);
      end
    end
  end

  // One request/acknowledge handshake, followed on the round-robin DUT.
  task automatic xact(input int p, input logic w, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic e, output int lat, output int nwr);
    @(posedge clk); #1;
    if (p == 0) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
    else begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
    lat = 0; nwr = 0; rd = 16'h0000; e = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mwr[0]) nwr++;
      if ((p == 0) ? ack0[0] : ack1[0]) begin
        lat = i; rd = rdata[0]; e = (p == 0) ? err0[0] : err1[0];
        break;
      end
    end
    if (lat == 0) chki("xact ack timeout", lat, 3);
    @(posedge clk); #1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  logic [15:0] rd;
  logic        e;
  int          lat, nwr;

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk1("reset ack0", ack0[k], 1'b0);
      chk1("reset busy", busy[k], 1'b0);
      chk1("reset memwrite", mwr[k], 1'b0);
      chk16("reset rdata", rdata[k], 16'h0000);
    end
    @(posedge clk); #1; rst_n = 1'b1;

    // Single store then load on port 0.
    xact(0, 1'b1, 16'h0010, 16'hBEEF, rd, e, lat, nwr);
    chki("store latency", lat, 3);
    chki("store memwrite cycles", nwr, 1);
    chk1("store err", e, 1'b0);
    xact(0, 1'b0, 16'h0010, 16'h0000, rd, e, lat, nwr);
    chk16("load beef", rd, 16'hBEEF);
    chki("load memwrite cycles", nwr, 0);

    // Boundaries: last legal word, then a store one byte past it.
    xact(0, 1'b0, 16'd126, 16'h0000, rd, e, lat, nwr);
    chk16("load 126", rd, 16'h7B7E);
    chk1("load 126 err", e, 1'b0);
    xact(1, 1'b1, 16'd127, 16'h1234, rd, e, lat, nwr);
    chk1("store 127 err", e, 1'b1);
    chki("store 127 memwrite cycles", nwr, 0);
    chk16("store 127 rdata", rd, 16'h0000);
    chk16("mem 126..127 unchanged", {dm[0][126], dm[0][127]}, 16'h7B7E);

    // Both requesting continuously (port 1 was granted last).
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0000;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0002;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk1("rr ack0 slot", ack0[0], (i % 3 == 0) && ((i / 3) % 2 == 1));
      chk1("rr ack1 slot", ack1[0], (i % 3 == 0) && ((i / 3) % 2 == 0));
      chk1("fp ack0 slot", ack0[1], (i % 3 == 0));
      chk1("fp ack1 slot", ack1[1], 1'b0);
      if (i == 3) chk16("rr data port0", rdata[0], 16'h0104);
      if (i == 6) chk16("rr data port1", rdata[0], 16'h070A);
    end
    @(posedge clk); #1; req0 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (ack1[1]) begin lat = i; break; end
    end
    chki("fp port1 after req0 drop", lat, 3);
    @(posedge clk); #1; req1 = 1'b0;

    // Port 1 store, then port 0 load of the same word right away.
    @(posedge clk); #1;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0040; wdata1 = 16'hA5A5;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (ack1[0]) begin lat = i; break; end
    end
    chki("b2b store latency", lat, 3);
    @(posedge clk); #1;
    req1 = 1'b0; req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0040;
    @(negedge clk);
    chk1("b2b idle busy", busy[0], 1'b0);
    @(posedge clk); #1;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0050; wdata1 = 16'hFFFF;
    @(negedge clk);
    chk1("b2b access busy", busy[0], 1'b1);
    chk1("b2b access memread", mrd[0], 1'b1);
    #1 req1 = 1'b0;
    @(negedge clk);
    chk1("b2b resp busy", busy[0], 1'b1);
    chk1("b2b resp ack0", ack0[0], 1'b1);
    chk16("b2b read new data", rdata[0], 16'hA5A5);
    @(posedge clk); #1; req0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("toggled req1 ignored", ack1[0], 1'b0);
    end
    chk16("mem 0x50 untouched", {dm[0][80], dm[0][81]}, 16'hF1F4);

    // Reset in the middle of a write access.
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h1111;
    @(posedge clk); #2;
    chk1("pre-reset memwrite", mwr[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("reset drops memwrite", mwr[0], 1'b0);
    chk1("reset drops busy", busy[0], 1'b0);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("no ack after reset", ack0[0], 1'b0);
    end

    // Recovery: fresh memory image after reset.
    xact(0, 1'b0, 16'h0010, 16'h0000, rd, e, lat, nwr);
    chk16("post-reset load", rd, 16'h3134);
    chki("post-reset latency", lat, 3);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
